mlp_top: RTL and testbench



---
 rtl/mlp_top.sv | 119 +++++++++++
 tb/tb_mlp_top.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mlp_top.sv
// Fixed-weight two-layer perceptron classifier: feature reg -> hidden ReLU layer -> argmax output.
// Optional bias terms are enabled by defining MLP_BIAS_EN; otherwise B1/B2 are treated as zero.
module mlp_top #(
  parameter int NUM_A    = 4,
  parameter int WIDTH_A  = 4,
  parameter int NUM_H    = 3,
  parameter int NUM_C    = 3,
  parameter int OUTWIDTH = 2,
  parameter int WW       = 8,
  parameter int SHIFT    = 4,
  parameter logic [NUM_H*NUM_A*WW-1:0] W1 = '0,
  parameter logic [NUM_H*WW-1:0]       B1 = '0,
  parameter logic [NUM_C*NUM_H*WW-1:0] W2 = '0,
  parameter logic [NUM_C*WW-1:0]       B2 = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_A*WIDTH_A-1:0]   inp,
  output logic [NUM_C-1:0]           predo,
  output logic [OUTWIDTH-1:0]        out
);

`ifdef MLP_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  // Accumulator widths chosen so that no sum of products can overflow.
  localparam int AW = WIDTH_A + WW + $clog2(NUM_A) + 2;
  localparam int SW = WIDTH_A + WW + $clog2(NUM_H) + 2;
  localparam logic signed [AW-1:0] ACT_MAX = AW'((1 << WIDTH_A) - 1);

  function automatic logic signed [AW-1:0] sext_aw(input logic [WW-1:0] w);
    return {{(AW-WW){w[WW-1]}}, w};
  endfunction

  function automatic logic signed [SW-1:0] sext_sw(input logic [WW-1:0] w);
    return {{(SW-WW){w[WW-1]}}, w};
  endfunction

  // ---------------- Stage 1: feature register ----------------
  logic [NUM_A*WIDTH_A-1:0] feat_q;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) feat_q <= '0;
    else     feat_q <= inp;
  end

  // ---------------- Stage 2: hidden layer ----------------
  logic signed [AW-1:0]  acc [NUM_H];
  logic signed [AW-1:0]  relu_sh [NUM_H];
  logic [WIDTH_A-1:0]    act_d [NUM_H];
  logic [WIDTH_A-1:0]    act_q [NUM_H];

  // NOTE: every variable is assigned a default at the top of the block so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int h = 0; h < NUM_H; h++) begin
      acc[h]     = BIAS_EN ? sext_aw(B1[h*WW +: WW]) : '0;
      relu_sh[h] = '0;
      act_d[h]   = '0;
      for (int a = 0; a < NUM_A; a++) begin
        acc[h] = acc[h] + sext_aw(W1[(h*NUM_A + a)*WW +: WW])
                        * $signed({{(AW-WIDTH_A){1'b0}}, feat_q[a*WIDTH_A +: WIDTH_A]});
      end
      // ReLU, then scale down; the value is non-negative here so >>> equals >>.
      relu_sh[h] = acc[h][AW-1] ? '0 : (acc[h] >>> SHIFT);
      act_d[h]   = (relu_sh[h] > ACT_MAX) ? {WIDTH_A{1'b1}} : relu_sh[h][WIDTH_A-1:0];
    end
  end

  // NOTE: the activation array is a pipeline register, not a memory, so every
  // entry is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < NUM_H; h++) act_q[h] <= '0;
    end else begin
      for (int h = 0; h < NUM_H; h++) act_q[h] <= act_d[h];
    end
  end

  // ---------------- Stage 3: output layer and argmax ----------------
  logic signed [SW-1:0]  score [NUM_C];
  logic signed [SW-1:0]  best_score;
  logic [OUTWIDTH-1:0]   best_idx;

  always_comb begin
    for (int c = 0; c < NUM_C; c++) begin
      score[c] = BIAS_EN ? sext_sw(B2[c*WW +: WW]) : '0;
      for (int h = 0; h < NUM_H; h++) begin
        score[c] = score[c] + sext_sw(W2[(c*NUM_H + h)*WW +: WW])
                            * $signed({{(SW-WIDTH_A){1'b0}}, act_q[h]});
      end
    end
    best_score = score[0];
    best_idx   = '0;
    // Strict comparison keeps the lowest index on ties.
    for (int c = 1; c < NUM_C; c++) begin
      if (score[c] > best_score) begin
        best_score = score[c];
        best_idx   = OUTWIDTH'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      predo <= NUM_C'(1);
    end else begin
      out   <= best_idx;
      predo <= NUM_C'(1) << best_idx;
    end
  end

endmodule

// File: tb/tb_mlp_top.sv
// Directed bench for mlp_top: four 2x2x2 configurations share clk/rst/inp and
// are checked against hand-computed results at fixed pipeline offsets.
module tb_mlp_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inp;

  logic [1:0] predo_id, predo_relu, predo_sat, predo_bias;
  logic       out_id, out_relu, out_sat, out_bias;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Identity weights, no biases.
  mlp_top #(.NUM_A(2), .WIDTH_A(4), .NUM_H(2), .NUM_C(2), .OUTWIDTH(1), .WW(8), .SHIFT(0),
            .W1(32'h0100_0001), .B1(16'h0000), .W2(32'h0100_0001), .B2(16'h0000))
    dut_id (.clk(clk), .rst(rst), .inp(inp), .predo(predo_id), .out(out_id));

  // Hidden row 0 = (-1, 0), row 1 = (0, 1).
  mlp_top #(.NUM_A(2), .WIDTH_A(4), .NUM_H(2), .NUM_C(2), .OUTWIDTH(1), .WW(8), .SHIFT(0),
            .W1(32'h0100_00FF), .B1(16'h0000), .W2(32'h0100_0001), .B2(16'h0000))
    dut_relu (.clk(clk), .rst(rst), .inp(inp), .predo(predo_relu), .out(out_relu));

  // Hidden weights 4 x identity.
  mlp_top #(.NUM_A(2), .WIDTH_A(4), .NUM_H(2), .NUM_C(2), .OUTWIDTH(1), .WW(8), .SHIFT(0),
            .W1(32'h0400_0004), .B1(16'h0000), .W2(32'h0100_0001), .B2(16'h0000))
    dut_sat (.clk(clk), .rst(rst), .inp(inp), .predo(predo_sat), .out(out_sat));

  // Output bias B2 = (0, 10).
  mlp_top #(.NUM_A(2), .WIDTH_A(4), .NUM_H(2), .NUM_C(2), .OUTWIDTH(1), .WW(8), .SHIFT(0),
            .W1(32'h0100_0001), .B1(16'h0000), .W2(32'h0100_0001), .B2(16'h0A00))
    dut_bias (.clk(clk), .rst(rst), .inp(inp), .predo(predo_bias), .out(out_bias));

`ifdef MLP_BIAS_EN
  localparam logic BIAS_OUT = 1'b1;
`else
  localparam logic BIAS_OUT = 1'b0;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // inp packing: feature 0 in the low nibble.
  function automatic logic [7:0] vec(input logic [3:0] x0, input logic [3:0] x1);
    return {x1, x0};
  endfunction

  initial begin
    // Reset held two edges with (3,5) on the input.
    rst = 1'b1;
    inp = vec(3, 5);
    step(1);
    check("rst1_out",   8'(out_id),   8'd0);
    check("rst1_predo", 8'(predo_id), 8'd1);
    step(1);
    check("rst2_out",   8'(out_id),   8'd0);
    check("rst2_predo", 8'(predo_id), 8'd1);
    check("rst2_bias_out", 8'(out_bias), 8'd0);
    rst = 1'b0;
    step(1);
    check("post1_out",   8'(out_id),   8'd0);
    check("post1_predo", 8'(predo_id), 8'd1);
    step(1);
    check("post2_out",   8'(out_id),   8'd0);
    check("post2_predo", 8'(predo_id), 8'd1);
    step(1);
    check("post3_out",   8'(out_id),   8'd1);
    check("post3_predo", 8'(predo_id), 8'd2);

    // Back-to-back: (3,5) then (9,2) on consecutive clocks.
    inp = vec(3, 5);
    step(1);
    inp = vec(9, 2);
    step(2);
    check("b2b_first_out",    8'(out_id),   8'd1);
    check("b2b_first_predo",  8'(predo_id), 8'd2);
    step(1);
    check("b2b_second_out",   8'(out_id),   8'd0);
    check("b2b_second_predo", 8'(predo_id), 8'd1);

    // Tie goes to the lowest index.
    inp = vec(4, 4);
    step(3);
    check("tie_out",   8'(out_id),   8'd0);
    check("tie_predo", 8'(predo_id), 8'd1);

    // Reversed order picks class 1.
    inp = vec(2, 9);
    step(3);
    check("swap_out", 8'(out_id), 8'd1);

    // ReLU: hidden = (max(0,-7), 2) = (0,2) -> class 1; identity net gives class 0.
    inp = vec(7, 2);
    step(3);
    check("relu_out",    8'(out_relu),   8'd1);
    check("relu_predo",  8'(predo_relu), 8'd2);
    check("relu_id_out", 8'(out_id),     8'd0);

    // Saturation: hidden = (min(60,15), 12) = (15,12) -> class 0.
    inp = vec(15, 3);
    step(3);
    check("sat_out",   8'(out_sat),   8'd0);
    check("sat_predo", 8'(predo_sat), 8'd1);

    // Saturation tie: hidden = (min(16,15), min(20,15)) = (15,15) -> class 0.
    inp = vec(4, 5);
    step(3);
    check("sat_tie_out", 8'(out_sat), 8'd0);
    check("sat_tie_id",  8'(out_id),  8'd1);

    // Output bias: scores (9, 2+10) with bias, (9, 2) without.
    inp = vec(9, 2);
    step(3);
    check("bias_out",   8'(out_bias),   8'(BIAS_OUT));
    check("bias_predo", 8'(predo_bias), BIAS_OUT ? 8'd2 : 8'd1);

    // Mid-stream reset discards in-flight vectors.
    inp = vec(3, 5);
    step(1);
    rst = 1'b1;
    step(1);
    check("mid_rst_out",   8'(out_id),   8'd0);
    check("mid_rst_predo", 8'(predo_id), 8'd1);
    rst = 1'b0;
    step(2);
    check("mid_post2_out", 8'(out_id), 8'd0);
    step(1);
    check("mid_post3_out", 8'(out_id), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
